// File: rtl/spiflash_rdcache_pkg.sv
// Shared types and address-field constants for the spimemio read cache.
package spiflash_rdcache_pkg;

  // spimemio decodes 16 MiB of flash; everything above bit 23 is ignored.
  localparam int FLASH_ADDR_W = 24;
  localparam int WORD_LSB     = 2;
  localparam int WORD_ADDR_W  = FLASH_ADDR_W - WORD_LSB;
  localparam int DATA_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_e;

  // Tag width left over once word-in-line and line index are removed.
  function automatic int tag_w(input int lines, input int line_words);
    return WORD_ADDR_W - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/spiflash_rdcache_mem.sv
// Tag and data storage for the read cache: one write port, registered data
// read. The tag is looked up combinationally so that the hit decision can be
// made in the request cycle and the ack still lands exactly one cycle later.
module spiflash_rdcache_mem
  import spiflash_rdcache_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int OFF_W = 2,
  parameter int TAG_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_word,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag
);

  logic [DATA_W-1:0] data_mem [2**(IDX_W+OFF_W)];
  logic [TAG_W-1:0]  tag_mem  [2**IDX_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  assign rd_data_d = data_mem[{rd_idx, rd_word}];
  assign rd_tag    = tag_mem[rd_idx];
  assign rd_data   = rd_data_q;

  // Array writes: fill words as they arrive, tag once the line is complete.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_word}] <= wr_data;
    if (tag_we) tag_mem[wr_idx] <= wr_tag;
  end

  // Registered read port; it doubles as the CPU read-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

endmodule

// File: rtl/spiflash_rdcache.sv
// Direct-mapped read-only line cache between the CPU Wishbone bus and the
// spimemio flash slave. Misses fetch a whole line as consecutive word reads so
// spimemio can stream every word after the first without a new command.
module spiflash_rdcache
  import spiflash_rdcache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] s_wb_adr_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  input  logic        s_wb_we_i,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_ack_o,
  input  logic        inv_i,
  output logic [31:0] m_wb_adr_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = tag_w(LINES, LINE_WORDS);
  localparam int IDX_LSB = WORD_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  state_e                 state_q, state_d;
  logic [WORD_ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic                   inv_seen_q, inv_seen_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic                   ack_q, ack_d;

  logic [OFF_W-1:0] req_word;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             s_req;
  logic             hit;
  logic             last_word;
  logic             mem_we;
  logic             tag_we;
  logic             unused_adr;

  assign req_word   = s_wb_adr_i[IDX_LSB-1:WORD_LSB];
  assign req_idx    = s_wb_adr_i[TAG_LSB-1:IDX_LSB];
  assign req_tag    = s_wb_adr_i[FLASH_ADDR_W-1:TAG_LSB];
  assign unused_adr = ^{s_wb_adr_i[31:FLASH_ADDR_W], s_wb_adr_i[WORD_LSB-1:0]};

  assign fill_idx  = fill_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag  = fill_addr_q[WORD_ADDR_W-1:OFF_W+IDX_W];

  // The ack mask keeps a request from being seen twice during its ack cycle.
  assign s_req     = s_wb_cyc_i & s_wb_stb_i & ~ack_q;
  assign hit       = valid_q[req_idx] & (rd_tag == req_tag);
  assign last_word = (cnt_q == {OFF_W{1'b1}});

  // The CPU read index is always taken from the bus; Wishbone holds the address
  // stable until ack, so it also selects the right word after a fill.
  spiflash_rdcache_mem #(
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_mem (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .rd_idx  (req_idx),
    .rd_word (req_word),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (mem_we),
    .wr_idx  (fill_idx),
    .wr_word (cnt_q),
    .wr_data (m_wb_dat_i),
    .tag_we  (tag_we),
    .wr_tag  (fill_tag)
  );

  // FSM state register; reset drops the flash cycle immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a read miss opens a fill, the last flash ack closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_req && !s_wb_we_i && !hit) state_d = FILL;
      FILL:    if (m_wb_ack_i && last_word) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: master cycle spans the whole line, array writes follow acks.
  always_comb begin
    m_wb_cyc_o = (state_q == FILL);
    m_wb_stb_o = (state_q == FILL);
    mem_we     = (state_q == FILL) && m_wb_ack_i;
    tag_we     = (state_q == FILL) && m_wb_ack_i && last_word;
  end

  // Datapath next values: line base latch, address stepping, valid bits, ack.
  always_comb begin
    fill_addr_d = fill_addr_q;
    cnt_d       = cnt_q;
    inv_seen_d  = inv_seen_q;
    valid_d     = valid_q;
    ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_req) begin
          if (s_wb_we_i || hit) begin
            ack_d = 1'b1;
          end else begin
            fill_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
            cnt_d       = '0;
            inv_seen_d  = 1'b0;
          end
        end
      end
      FILL: begin
        if (inv_i) inv_seen_d = 1'b1;
        if (m_wb_ack_i) begin
          // Stepping by one word matches spimemio's rd_addr+4, so the stream continues.
          fill_addr_d = fill_addr_q + WORD_ADDR_W'(1);
          cnt_d       = cnt_q + OFF_W'(1);
          if (last_word && !inv_seen_q && !inv_i) valid_d[fill_idx] = 1'b1;
        end
      end
      RESP: begin
        // The CPU may have abandoned the cycle during the fill; ack only if still waiting.
        ack_d = s_req;
      end
      default: ;
    endcase
    // The hit decision above used the old valid bits, so a simultaneous hit is still served.
    if (inv_i) valid_d = '0;
  end

  // Datapath registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fill_addr_q <= '0;
      cnt_q       <= '0;
      inv_seen_q  <= 1'b0;
      valid_q     <= '0;
      ack_q       <= 1'b0;
    end else begin
      fill_addr_q <= fill_addr_d;
      cnt_q       <= cnt_d;
      inv_seen_q  <= inv_seen_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
    end
  end

  assign s_wb_ack_o = ack_q;
  assign s_wb_dat_o = rd_data;
  assign m_wb_adr_o = {{(32-FLASH_ADDR_W){1'b0}}, fill_addr_q, 2'b00};

endmodule

// File: tb/tb_spiflash_rdcache.sv
// Scoreboard bench for spiflash_rdcache: a driver issues CPU transactions and
// predicts each response from a line-level cache model; a monitor checks every
// CPU ack and every flash beat against those predictions.
module tb_spiflash_rdcache;

  localparam int LINES = 16;
  localparam int LW    = 4;

  logic        clk;
  logic        rst;
  logic [31:0] s_adr;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_dat;
  logic        s_ack;
  logic        inv;
  logic [31:0] m_adr;
  logic        m_cyc, m_stb;
  logic [31:0] m_dat;
  logic        m_ack;
  logic        fl_rdy;
  logic        rnd_mode;

  spiflash_rdcache #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .s_wb_adr_i (s_adr),
    .s_wb_cyc_i (s_cyc),
    .s_wb_stb_i (s_stb),
    .s_wb_we_i  (s_we),
    .s_wb_dat_o (s_dat),
    .s_wb_ack_o (s_ack),
    .inv_i      (inv),
    .m_wb_adr_o (m_adr),
    .m_wb_cyc_o (m_cyc),
    .m_wb_stb_o (m_stb),
    .m_wb_dat_i (m_dat),
    .m_wb_ack_i (m_ack)
  );

  // Flash contents: a fixed scramble of the word address.
  function automatic logic [31:0] fdata(input logic [31:0] a);
    logic [31:0] w;
    w = {8'h00, a[23:2], 2'b00};
    return w * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  // spimemio stand-in: combinational ack, optionally with wait states.
  assign m_ack = m_cyc & m_stb & fl_rdy;
  assign m_dat = fdata(m_adr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    fl_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fl_rdy = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  typedef struct {
    bit          is_wr;
    bit          miss;
    logic [31:0] data;
    int          fills;
    logic [31:0] base;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t sb[$];
  chk_t chkq[$];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: owns all counters; also drains point checks queued by the driver.
  initial begin
    int          fills = 0;
    int          beats = 0;
    int          lat   = 0;
    logic [31:0] first_adr = '0;
    logic        cyc_prev = 1'b0;
    exp_t        e;
    chk_t        c;
    forever begin
      @(negedge clk);
      while (chkq.size() > 0) begin
        c = chkq.pop_front();
        check(c.nm, c.act, c.exp);
      end
      if (m_cyc && !cyc_prev) begin
        fills++;
        beats     = 0;
        first_adr = m_adr;
      end
      if (m_cyc && m_stb && m_ack) begin
        check("beat_adr", m_adr, first_adr + 32'(4 * beats));
        beats++;
      end
      cyc_prev = m_cyc;
      if (s_ack) begin
        if (sb.size() == 0) begin
          check("spurious_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (!e.is_wr) check("rd_data", s_dat, e.data);
          check("fill_count", 32'(fills), 32'(e.fills));
          if (e.fills > 0) begin
            check("fill_base", first_adr, e.base);
            check("fill_beats", 32'(beats), 32'(LW));
          end
          if (e.miss) check("miss_latency_min", 32'(lat >= LW + 2), 32'd1);
          else        check("hit_latency", 32'(lat), 32'd1);
        end
        fills = 0;
        lat   = 0;
      end else if (s_cyc && s_stb) begin
        lat++;
      end else begin
        lat = 0;
      end
    end
  end

  // Reference model: which flash line each cache slot holds.
  bit          mv[LINES];
  int unsigned mline[LINES];
  int          orphan    = 0;
  logic [31:0] last_base = '0;

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a & 32'h00FF_FFFF) / (LW * 4);
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    int unsigned ln;
    ln = line_of(a);
    return mv[ln % LINES] && (mline[ln % LINES] == ln);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endfunction

  // One CPU transaction; inv_at=n pulses inv_i so the DUT samples it n edges after the request.
  task automatic do_req(input logic [31:0] a, input bit we, input int inv_at);
    exp_t        e;
    int unsigned ln;
    bit          done;
    ln      = line_of(a);
    e.is_wr = we;
    e.miss  = !we && !is_hit(a);
    e.data  = fdata(a);
    if (e.miss) begin
      e.fills   = orphan + 1;
      e.base    = 32'(ln * LW * 4);
      last_base = e.base;
    end else begin
      e.fills = orphan;
      e.base  = last_base;
    end
    orphan = 0;
    if (inv_at > 0) model_clear();
    if (e.miss && inv_at <= 1) begin
      mv[ln % LINES]    = 1'b1;
      mline[ln % LINES] = ln;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    s_adr = a;
    s_we  = we;
    s_cyc = 1'b1;
    s_stb = 1'b1;
    inv   = (inv_at == 1);
    done  = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(posedge clk);
      #1;
      inv = (inv_at == n + 1);
      if (s_ack) done = 1'b1;
    end
    s_cyc = 1'b0;
    s_stb = 1'b0;
    inv   = 1'b0;
    if (!done) chkq.push_back('{nm: "ack_timeout", act: 32'd0, exp: 32'd1});
  endtask

  task automatic pulse_inv();
    @(posedge clk);
    #1 inv = 1'b1;
    @(posedge clk);
    #1 inv = 1'b0;
    model_clear();
  endtask

  // Main stimulus.
  initial begin
    logic [31:0] a;
    bit          we;
    int          inv_at;
    rst = 1'b0; rnd_mode = 1'b0;
    s_adr = '0; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; inv = 1'b0;
    model_clear();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkq.push_back('{nm: "rst_s_ack", act: 32'(s_ack), exp: 32'd0});
    chkq.push_back('{nm: "rst_s_dat", act: s_dat, exp: 32'd0});
    chkq.push_back('{nm: "rst_m_cyc", act: 32'({m_cyc, m_stb}), exp: 32'd0});
    chkq.push_back('{nm: "rst_m_adr", act: m_adr, exp: 32'd0});
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold miss, then hit in the same line, then a conflicting tag at index 0.
    do_req(32'h0000_0104, 1'b0, 0);
    do_req(32'h0000_010C, 1'b0, 0);
    do_req(32'h0000_0200, 1'b0, 0);
    do_req(32'h0000_0100, 1'b0, 0);

    // Invalidate: standalone pulse, mid-fill pulse, and pulse alongside a hit.
    pulse_inv();
    do_req(32'h0000_0104, 1'b0, 0);
    do_req(32'h0000_0304, 1'b0, 3);
    do_req(32'h0000_0304, 1'b0, 0);
    do_req(32'h0000_0308, 1'b0, 1);
    do_req(32'h0000_0308, 1'b0, 0);

    // Writes are acked without flash traffic; upper address byte is ignored.
    do_req(32'h0000_0104, 1'b1, 0);
    do_req(32'h2A00_0104, 1'b0, 0);

    // Reset during the third fill word.
    @(posedge clk);
    #1;
    s_adr = 32'h0000_0504; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chkq.push_back('{nm: "midfill_rst_m_cyc", act: 32'({m_cyc, m_stb}), exp: 32'd0});
    chkq.push_back('{nm: "midfill_rst_m_adr", act: m_adr, exp: 32'd0});
    s_cyc = 1'b0; s_stb = 1'b0;
    model_clear();
    orphan++;
    last_base = 32'h0000_0500;
    @(posedge clk);
    #1 rst = 1'b0;
    do_req(32'h0000_0104, 1'b0, 0);

    // CPU abandons a miss mid-fill: no ack, but the line becomes valid.
    @(posedge clk);
    #1;
    s_adr = 32'h0000_0604; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    repeat (2) @(posedge clk);
    #1 s_cyc = 1'b0; s_stb = 1'b0;
    repeat (10) @(posedge clk);
    mv[line_of(32'h604) % LINES]    = 1'b1;
    mline[line_of(32'h604) % LINES] = line_of(32'h604);
    orphan++;
    last_base = 32'h0000_0600;
    do_req(32'h0000_0608, 1'b0, 0);

    // Randomized traffic over a small region with flash wait states.
    rnd_mode = 1'b1;
    for (int t = 0; t < 300; t++) begin
      a  = ($urandom() & 32'hFF00_0000) | ($urandom_range(0, 32'h7FF) & 32'hFFFF_FFFC);
      we = ($urandom_range(0, 9) == 0);
      inv_at = 0;
      if ($urandom_range(0, 15) == 0)
        inv_at = (!we && !is_hit(a)) ? int'($urandom_range(1, LW + 1)) : 1;
      if ($urandom_range(0, 29) == 0) pulse_inv();
      do_req(a, we, inv_at);
    end

    repeat (10) @(posedge clk);
    chkq.push_back('{nm: "sb_drained", act: 32'(sb.size()), exp: 32'd0});
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
